// File: rtl/muldiv_seq_if.sv
// Execute-stage handshake for the M-extension sequencer.
// Master is the pipeline side, slave is the sequencer.
interface muldiv_seq_if #(parameter int XLEN = 32);
    logic            valid_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            flush_i;
    logic            stall_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (output valid_i, funct3_i, a_i, b_i, flush_i,
                    input  stall_o, done_o, result_o);
    modport slave  (input  valid_i, funct3_i, a_i, b_i, flush_i,
                    output stall_o, done_o, result_o);
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M mul/div: 34 cycles per op (2 for div-by-zero/overflow), result held one DONE cycle.
// Backpressure: stall is combinational on the incoming op and drops in DONE; flush aborts silently.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_seq_if.slave   bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state;
    logic [2:0]        op;
    logic              negRes;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   mcand;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   result;
    logic              done;

    logic              aNeg, bNeg, negIn, divZero, divOvf;
    logic [XLEN-1:0]   aMag, bMag, earlyRes;
    logic [XLEN:0]     sum, shifted, diff;
    logic [2*XLEN-1:0] nextAcc, fullCorr;
    logic [XLEN-1:0]   quoCorr, remCorr, finalRes;

    always_comb begin
        aNeg = 1'b0;
        bNeg = 1'b0;
        case (bus.funct3_i)
            3'd1, 3'd4, 3'd6: begin
                aNeg = bus.a_i[XLEN-1];
                bNeg = bus.b_i[XLEN-1];
            end
            3'd2:    aNeg = bus.a_i[XLEN-1];
            default: ;
        endcase
        aMag = aNeg ? -bus.a_i : bus.a_i;
        bMag = bNeg ? -bus.b_i : bus.b_i;
        // Remainder follows the dividend; everything else is the product/quotient sign.
        negIn = (bus.funct3_i[2] && bus.funct3_i[1]) ? aNeg : (aNeg ^ bNeg);
        divZero = bus.funct3_i[2] && (bus.b_i == '0);
        divOvf  = bus.funct3_i[2] && !bus.funct3_i[0]
                  && (bus.a_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b_i == '1);
        if (divZero)
            earlyRes = bus.funct3_i[1] ? bus.a_i : '1;
        else
            earlyRes = bus.funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    always_comb begin
        sum     = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mcand};
        shifted = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff    = shifted - {1'b0, mcand};
        if (op[2])
            nextAcc = diff[XLEN] ? {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                 : {diff[XLEN-1:0],    acc[XLEN-2:0], 1'b1};
        else
            nextAcc = acc[0] ? {sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
        fullCorr = negRes ? -nextAcc : nextAcc;
        quoCorr  = negRes ? -nextAcc[XLEN-1:0] : nextAcc[XLEN-1:0];
        remCorr  = negRes ? -nextAcc[2*XLEN-1:XLEN] : nextAcc[2*XLEN-1:XLEN];
        case (op)
            3'd0:             finalRes = fullCorr[XLEN-1:0];
            3'd1, 3'd2, 3'd3: finalRes = fullCorr[2*XLEN-1:XLEN];
            3'd4, 3'd5:       finalRes = quoCorr;
            default:          finalRes = remCorr;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op     <= '0;
            negRes <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            acc    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.valid_i && !bus.flush_i) begin
                        op     <= bus.funct3_i;
                        negRes <= negIn;
                        cnt    <= '0;
                        mcand  <= bMag;
                        acc    <= {{XLEN{1'b0}}, aMag};
                        if (divZero || divOvf) begin
                            result <= earlyRes;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (bus.flush_i) begin
                        state <= IDLE;
                    end else begin
                        acc <= nextAcc;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(XLEN-1)) begin
                            result <= finalRes;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.stall_o  = bus.valid_i && !bus.flush_i && (state != DONE);
    assign bus.done_o   = done;
    assign bus.result_o = result;
endmodule
